btb_2way_predictor: RTL

Two-way set-associative branch target buffer with per-entry 2-bit saturating direction counters and per-set LRU replacement. It sits in the fetch stage and is looked up combinationally with the fetch PC every cycle. It is trained from the execute stage through a single update port carrying the resolved branch PC, target and outcome. It replaces the direct-mapped, always-taken BTB: set count, PC width and counter initial value are now parameters.

---
 rtl/btb_2way_predictor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/btb_2way_predictor.sv
// Two-way set-associative branch target buffer with 2-bit direction counters
// and per-set LRU replacement; combinational lookup, single training port.
module btb_2way_predictor #(
  parameter int         SET_BITS = 5,
  parameter int         PC_BITS  = 11,
  parameter int         TAG_BITS = PC_BITS - SET_BITS,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] pc_fetch,
  input  logic               wr_enable,
  input  logic [PC_BITS-1:0] new_pc_fetch,
  input  logic [PC_BITS-1:0] new_pc_target,
  input  logic               new_taken,
  input  logic               flush,
  output logic               hit,
  output logic               hit_way,
  output logic               predict_taken,
  output logic [PC_BITS-1:0] pc_target_prediction
);

  localparam int SETS = 1 << SET_BITS;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    cnt_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    cnt_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0]      lru_q, lru_d;
  logic [TAG_BITS-1:0]  tag_q [2][SETS];
  logic [TAG_BITS-1:0]  tag_d [2][SETS];
  logic [PC_BITS-1:0]   tgt_q [2][SETS];
  logic [PC_BITS-1:0]   tgt_d [2][SETS];
  logic [1:0]           cnt_q [2][SETS];
  logic [1:0]           cnt_d [2][SETS];

  logic [SET_BITS-1:0]  rd_idx_s, wr_idx_s;
  logic [TAG_BITS-1:0]  rd_tag_s, wr_tag_s;
  logic [1:0]           rd_match_s, wr_match_s;
  logic                 wr_way_s, victim_s;

  assign rd_idx_s = pc_fetch[SET_BITS-1:0];
  assign rd_tag_s = pc_fetch[PC_BITS-1:SET_BITS];
  assign wr_idx_s = new_pc_fetch[SET_BITS-1:0];
  assign wr_tag_s = new_pc_fetch[PC_BITS-1:SET_BITS];

  // Tag compare for both the fetch lookup and the training port
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      rd_match_s[w] = valid_q[w][rd_idx_s] && (tag_q[w][rd_idx_s] == rd_tag_s);
      wr_match_s[w] = valid_q[w][wr_idx_s] && (tag_q[w][wr_idx_s] == wr_tag_s);
    end
  end

  // Fetch-side prediction; way 0 wins should both ways ever match
  always_comb begin
    hit                  = |rd_match_s;
    hit_way              = 1'b0;
    predict_taken        = 1'b0;
    pc_target_prediction = {PC_BITS{1'b0}};
    if (rd_match_s[0]) begin
      predict_taken        = cnt_q[0][rd_idx_s][1];
      pc_target_prediction = tgt_q[0][rd_idx_s];
    end else if (rd_match_s[1]) begin
      hit_way              = 1'b1;
      predict_taken        = cnt_q[1][rd_idx_s][1];
      pc_target_prediction = tgt_q[1][rd_idx_s];
    end else begin
      hit_way              = 1'b0;
    end
  end

  // Hit way on the training port and replacement victim (first invalid, else LRU)
  always_comb begin
    wr_way_s = wr_match_s[0] ? 1'b0 : 1'b1;
    if (!valid_q[0][wr_idx_s]) begin
      victim_s = 1'b0;
    end else if (!valid_q[1][wr_idx_s]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_q[wr_idx_s];
    end
  end

  // Next-state for training; flush overrides and drops a same-cycle update
  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = '0;
      lru_d   = '0;
    end else if (wr_enable) begin
      if (|wr_match_s) begin
        if (new_taken) begin
          cnt_d[wr_way_s][wr_idx_s] = cnt_inc(cnt_q[wr_way_s][wr_idx_s]);
          tgt_d[wr_way_s][wr_idx_s] = new_pc_target;
        end else begin
          cnt_d[wr_way_s][wr_idx_s] = cnt_dec(cnt_q[wr_way_s][wr_idx_s]);
        end
        lru_d[wr_idx_s] = ~wr_way_s;
      end else if (new_taken) begin
        valid_d[victim_s][wr_idx_s] = 1'b1;
        tag_d[victim_s][wr_idx_s]   = wr_tag_s;
        tgt_d[victim_s][wr_idx_s]   = new_pc_target;
        cnt_d[victim_s][wr_idx_s]   = CNT_INIT;
        lru_d[wr_idx_s]             = ~victim_s;
      end else begin
        lru_d = lru_q;
      end
    end else begin
      lru_d = lru_q;
    end
  end

  // Valid and LRU bits are the only reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Payload storage is don't-care while invalid, so it carries no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    cnt_q <= cnt_d;
  end

endmodule
